// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle layout, bubble encoding and counter limits.
package pipe_pkg;

    localparam int CTRL_W = 10;

    // Bundle order, MSB first: RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc
    localparam int CTRL_REGWRITE  = 9;
    localparam int CTRL_RESSRC_LO = 7;
    localparam int CTRL_MEMWRITE  = 6;
    localparam int CTRL_JUMP      = 5;
    localparam int CTRL_BRANCH    = 4;
    localparam int CTRL_ALUCTL_LO = 1;
    localparam int CTRL_ALUSRC    = 0;

    localparam logic [CTRL_W-1:0] CTRL_NOP = 10'd0;

    localparam logic [31:0] BUBBLE_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/id_ex_reg_flopenrc.sv
// Parameterised flop with synchronous active-low reset, synchronous clear and load enable.
module flopenrc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear beats enable so a flush during a stall still inserts a bubble.
    always_ff @(posedge clk) begin
        if (!reset)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall, flush and valid tracking.
// Optional flush counter on BubbleCount when ID_EX_BUBBLE_COUNT_EN is defined.
module id_ex_reg
    import pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            ValidD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            BranchD,
    input  logic            ALUSrcD,
    input  logic [1:0]      ResultSrcD,
    input  logic [2:0]      ALUControlD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [RA_W-1:0] Rs1D,
    input  logic [RA_W-1:0] Rs2D,
    input  logic [RA_W-1:0] RdD,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [RA_W-1:0] Rs1E,
    output logic [RA_W-1:0] Rs2E,
    output logic [RA_W-1:0] RdE,
    output logic            ValidE,
    output logic [31:0]     BubbleCount
);

    localparam int DATA_W = 5*XLEN + 3*RA_W;

    logic [CTRL_W-1:0] ctrl_d;
    logic [CTRL_W-1:0] ctrl_e;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_e;

    assign ctrl_d = {RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD, ALUSrcD};
    assign data_d = {RD1D, RD2D, PCD, ImmExtD, PCPlus4D, Rs1D, Rs2D, RdD};

    // Clearing the flop yields CTRL_NOP and ValidE=0 together.
    flopenrc #(.WIDTH(CTRL_W + 1)) u_ctrl (
        .clk   (clk),
        .reset (reset),
        .en    (~StallE),
        .clr   (FlushE),
        .d     ({ctrl_d, ValidD}),
        .q     ({ctrl_e, ValidE})
    );

    flopenrc #(.WIDTH(DATA_W)) u_data (
        .clk   (clk),
        .reset (reset),
        .en    (~StallE),
        .clr   (FlushE),
        .d     (data_d),
        .q     (data_e)
    );

    assign RegWriteE   = ctrl_e[CTRL_REGWRITE];
    assign ResultSrcE  = ctrl_e[CTRL_RESSRC_LO +: 2];
    assign MemWriteE   = ctrl_e[CTRL_MEMWRITE];
    assign JumpE       = ctrl_e[CTRL_JUMP];
    assign BranchE     = ctrl_e[CTRL_BRANCH];
    assign ALUControlE = ctrl_e[CTRL_ALUCTL_LO +: 3];
    assign ALUSrcE     = ctrl_e[CTRL_ALUSRC];

    assign {RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE} = data_e;

`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [31:0] bubble_cnt;

    // Counts flushes even while stalled; saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset)
            bubble_cnt <= '0;
        else if (FlushE && (bubble_cnt != BUBBLE_MAX))
            bubble_cnt <= bubble_cnt + 32'd1;
    end

    assign BubbleCount = bubble_cnt;
`else
    assign BubbleCount = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: per-cycle model comparison plus directed literal checks.
module tb_id_ex_reg;

    typedef struct packed {
        logic        regw;
        logic [1:0]  ressrc;
        logic        memw;
        logic        jump;
        logic        branch;
        logic [2:0]  aluctl;
        logic        alusrc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] pcp4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        valid;
    } stage_t;

    logic clk = 1'b0;
    logic reset;
    logic stall;
    logic flush;
    stage_t d;
    stage_t e_dut;
    stage_t exp_e;
    logic [31:0] exp_bc;
    logic [31:0] bc;
    logic chk_en = 1'b0;
    int n_checks = 0;
    int n_errors = 0;

    logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;

    always #5 clk = ~clk;

    id_ex_reg #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .reset(reset), .StallE(stall), .FlushE(flush), .ValidD(d.valid),
        .RegWriteD(d.regw), .MemWriteD(d.memw), .JumpD(d.jump), .BranchD(d.branch),
        .ALUSrcD(d.alusrc), .ResultSrcD(d.ressrc), .ALUControlD(d.aluctl),
        .RD1D(d.rd1), .RD2D(d.rd2), .PCD(d.pc), .ImmExtD(d.imm), .PCPlus4D(d.pcp4),
        .Rs1D(d.rs1), .Rs2D(d.rs2), .RdD(d.rd),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE), .BubbleCount(bc)
    );

    assign e_dut = {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE,
                    RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE};

    // Reference behaviour: reset > flush > stall > load, one-cycle latency.
    always @(posedge clk) begin
        if (!reset) begin
            exp_e  = '0;
            exp_bc = 32'd0;
        end else begin
            if (flush)
                exp_e = '0;
            else if (!stall)
                exp_e = d;
`ifdef ID_EX_BUBBLE_COUNT_EN
            if (flush && exp_bc != 32'hFFFF_FFFF)
                exp_bc = exp_bc + 32'd1;
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (e_dut !== exp_e) begin
                n_errors++;
                $display("FAIL stage_regs t=%0t: got %h expected %h", $time, e_dut, exp_e);
            end
            n_checks++;
            if (bc !== exp_bc) begin
                n_errors++;
                $display("FAIL bubble_count t=%0t: got %h expected %h", $time, bc, exp_bc);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [31:0] exp_flush_bc;

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        d     = '1;
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_pce", PCE, 32'h0);
        chk("rst_rd1e", RD1E, 32'h0);
        chk("rst_rde", {27'd0, RdE}, 32'h0);
        chk("rst_regwrite", {31'd0, RegWriteE}, 32'h0);
        chk("rst_valid", {31'd0, ValidE}, 32'h0);
        chk("rst_bubble", bc, 32'h0);

        reset = 1'b1;
        d = '0;
        d.regw = 1'b1; d.aluctl = 3'b010; d.rd1 = 32'h1234_5678; d.rd = 5'd7; d.valid = 1'b1;
        tick();
        chk("pass_regwrite", {31'd0, RegWriteE}, 32'h1);
        chk("pass_aluctl", {29'd0, ALUControlE}, 32'h2);
        chk("pass_rd1", RD1E, 32'h1234_5678);
        chk("pass_rd", {27'd0, RdE}, 32'd7);
        chk("pass_valid", {31'd0, ValidE}, 32'h1);

        d.pc = 32'h100;
        tick();
        chk("stall_load", PCE, 32'h100);
        stall = 1'b1;
        d.pc = 32'h104;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_pc", PCE, 32'h100);
            chk("stall_hold_valid", {31'd0, ValidE}, 32'h1);
        end
        stall = 1'b0;
        tick();
        chk("stall_release", PCE, 32'h104);

        d.memw = 1'b1; d.rd = 5'd9; d.rd1 = 'x;
        stall = 1'b1; flush = 1'b1;
        tick();
        chk("flush_memwrite", {31'd0, MemWriteE}, 32'h0);
        chk("flush_rd", {27'd0, RdE}, 32'h0);
        chk("flush_rd1_no_x", RD1E, 32'h0);
        chk("flush_valid", {31'd0, ValidE}, 32'h0);
`ifdef ID_EX_BUBBLE_COUNT_EN
        exp_flush_bc = 32'd1;
`else
        exp_flush_bc = 32'd0;
`endif
        chk("flush_bubble", bc, exp_flush_bc);
        stall = 1'b0; flush = 1'b0;
        d = '0;

        d.regw = 1'b1; d.valid = 1'b1;
        tick();
        chk("pre_rst_regwrite", {31'd0, RegWriteE}, 32'h1);
        stall = 1'b1; reset = 1'b0;
        tick();
        chk("midstall_rst_regwrite", {31'd0, RegWriteE}, 32'h0);
        chk("midstall_rst_valid", {31'd0, ValidE}, 32'h0);
        chk("midstall_rst_bubble", bc, 32'h0);
        reset = 1'b1; stall = 1'b0;

        d.regw = 1'b1; d.memw = 1'b1; d.valid = 1'b0;
        tick();
        chk("invalid_memwrite", {31'd0, MemWriteE}, 32'h1);
        chk("invalid_valid", {31'd0, ValidE}, 32'h0);

        // Mixed traffic checked by the per-cycle comparator.
        for (int i = 0; i < 16; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            stall = (i % 4 == 1) || (i % 5 == 2);
            flush = (i % 6 == 3);
            tick();
        end
        stall = 1'b0; flush = 1'b0;

`ifdef ID_EX_BUBBLE_COUNT_EN
        force dut.bubble_cnt = 32'hFFFF_FFFE;
        exp_bc = 32'hFFFF_FFFE;
        #1;
        release dut.bubble_cnt;
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bubble_saturate", bc, 32'hFFFF_FFFF);
        end
`else
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bubble_disabled", bc, 32'h0);
        end
`endif
        flush = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
